// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS7 receiver and generator.
// Holds the LFSR order and tap positions, the receiver state encoding,
// the default window length and a saturating-increment helper.
package prbs_pkg;

   localparam int PRBS_ORDER = 7;
   localparam int TAP_HI     = 6;
   localparam int TAP_LO     = 5;

   localparam logic [15:0] WINDOW_LEN_DEFAULT = 16'd50000;
   localparam logic [31:0] CNT_MAX            = 32'hFFFF_FFFF;
   localparam int          RESYNC_MISSES      = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      MEASURE = 2'd2,
      REPORT  = 2'd3
   } prbs_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/prbs_receiver_if.sv
// prbs_receiver_if: bundles the receiver's stream input, measurement request
// and result/debug outputs.
//   master : drives bit_in, get_word; observes results
//   slave  : the receiver itself
interface prbs_receiver_if;
   import prbs_pkg::*;

   logic                  bit_in;
   logic                  get_word;
   logic [31:0]           error_bits_out;
   logic [31:0]           total_bits_out;
   logic                  send_data;
   logic [PRBS_ORDER-1:0] wordtest;
   logic [15:0]           countertest;
   logic                  bitin;
   logic                  bitout;

   modport master (
      output bit_in, get_word,
      input  error_bits_out, total_bits_out, send_data,
             wordtest, countertest, bitin, bitout
   );

   modport slave (
      input  bit_in, get_word,
      output error_bits_out, total_bits_out, send_data,
             wordtest, countertest, bitin, bitout
   );
endinterface

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: one combinational step of the x^7+x^6+1 sequence.
// Bit 0 of the state is the newest bit.
//   state_i : current 7-bit state
//   fb_o    : next sequence bit, state[6]^state[5]
//   next_o  : state after shifting fb_o in
module prbs7_lfsr
   import prbs_pkg::*;
(
   input  logic [PRBS_ORDER-1:0] state_i,
   output logic                  fb_o,
   output logic [PRBS_ORDER-1:0] next_o
);

   assign fb_o   = state_i[TAP_HI] ^ state_i[TAP_LO];
   assign next_o = {state_i[PRBS_ORDER-2:0], fb_o};

endmodule

// File: rtl/prbs_gen.sv
// prbs_gen: PRBS7 source with programmable bit-error injection.
// A free-running 16-bit maximal LFSR supplies the random value; a bit is
// inverted when that value is below error_rate_i, i.e. with probability
// about error_rate_i/65536.
//   clk, rst     : system clock, synchronous active-high reset
//   error_rate_i : inversion threshold (0 = clean stream)
//   bit_o        : registered serial output
module prbs_gen
   import prbs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] error_rate_i,
   output logic        bit_o
);

   logic [PRBS_ORDER-1:0] lfsr_q;
   logic [PRBS_ORDER-1:0] lfsr_d;
   logic                  fb_w;
   logic [15:0]           rnd_q;
   logic                  rnd_fb_w;
   logic                  bit_q;

   prbs7_lfsr u_lfsr (
      .state_i (lfsr_q),
      .fb_o    (fb_w),
      .next_o  (lfsr_d)
   );

   // x^16+x^14+x^13+x^11+1, never reaches zero from a nonzero seed
   assign rnd_fb_w = rnd_q[15] ^ rnd_q[13] ^ rnd_q[12] ^ rnd_q[10];

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 7'h7F;
         rnd_q  <= 16'hACE1;
         bit_q  <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         rnd_q  <= {rnd_q[14:0], rnd_fb_w};
         bit_q  <= fb_w ^ (rnd_q < error_rate_i);
      end
   end

   assign bit_o = bit_q;

endmodule

// File: rtl/prbs_receiver.sv
// prbs_receiver: PRBS7 bit-error-rate receiver.
// On get_word it locks a local PRBS7 copy onto the incoming stream, then
// compares WINDOW_LEN bits against the self-running prediction and reports
// mismatch/compared counts with a one-cycle send_data strobe.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : prbs_receiver_if.slave (bit_in, get_word in; results and
//              debug taps wordtest/countertest/bitin/bitout out)
// Optional build macro PRBS_RESYNC_EN: 16 consecutive mismatches in MEASURE
// send the FSM back to SYNC, keeping the window counts.
//
// state   | meaning
// IDLE    | waiting for get_word
// SYNC    | loading 7 received bits into the local PRBS state
// MEASURE | comparing received bits with the local prediction
// REPORT  | one cycle: results valid, send_data high
module prbs_receiver
   import prbs_pkg::*;
#(
   parameter logic [15:0] WINDOW_LEN = WINDOW_LEN_DEFAULT
)(
   input logic             clk,
   input logic             rst,
   prbs_receiver_if.slave  bus
);

   prbs_state_e           state_q;
   logic [PRBS_ORDER-1:0] wordtest_q;
   logic [PRBS_ORDER-1:0] wordtest_pred_d;
   logic [PRBS_ORDER-1:0] wordtest_sync_d;
   logic [15:0]           countertest_q;
   logic [2:0]            sync_cnt_q;
   logic                  bitin_q;
   logic                  bitout_w;
   logic                  mismatch_w;
   logic [31:0]           err_cnt_q;
   logic [31:0]           tot_cnt_q;
   logic [31:0]           err_out_q;
   logic [31:0]           tot_out_q;
   logic                  send_q;
`ifdef PRBS_RESYNC_EN
   logic [4:0]            miss_run_q;
`endif

   prbs7_lfsr u_lfsr (
      .state_i (wordtest_q),
      .fb_o    (bitout_w),
      .next_o  (wordtest_pred_d)
   );

   assign wordtest_sync_d = {wordtest_q[PRBS_ORDER-2:0], bitin_q};
   assign mismatch_w      = bitin_q ^ bitout_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wordtest_q    <= '0;
         countertest_q <= '0;
         sync_cnt_q    <= '0;
         bitin_q       <= 1'b0;
         err_cnt_q     <= '0;
         tot_cnt_q     <= '0;
         err_out_q     <= '0;
         tot_out_q     <= '0;
         send_q        <= 1'b0;
`ifdef PRBS_RESYNC_EN
         miss_run_q    <= '0;
`endif
      end else begin
         bitin_q <= bus.bit_in;
         send_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.get_word) begin
                  state_q       <= SYNC;
                  countertest_q <= '0;
                  sync_cnt_q    <= '0;
                  err_cnt_q     <= '0;
                  tot_cnt_q     <= '0;
`ifdef PRBS_RESYNC_EN
                  miss_run_q    <= '0;
`endif
               end
            end
            SYNC: begin
               wordtest_q <= wordtest_sync_d;
               if (sync_cnt_q == 3'd6) begin
                  sync_cnt_q <= '0;
                  // all-zero state is the LFSR lock-up point: keep loading
                  if (wordtest_sync_d != '0) begin
                     state_q <= MEASURE;
                  end
               end else begin
                  sync_cnt_q <= sync_cnt_q + 3'd1;
               end
            end
            MEASURE: begin
               // the window is closed one cycle after the last compare so
               // that send_data lands WINDOW_LEN+8 cycles after get_word
               if (countertest_q == WINDOW_LEN) begin
                  state_q   <= REPORT;
                  err_out_q <= err_cnt_q;
                  tot_out_q <= tot_cnt_q;
                  send_q    <= 1'b1;
               end else begin
                  // predicted bit is fed back so a line error is counted once
                  wordtest_q    <= wordtest_pred_d;
                  countertest_q <= countertest_q + 16'd1;
                  tot_cnt_q     <= sat_inc(tot_cnt_q);
                  if (mismatch_w) begin
                     err_cnt_q <= sat_inc(err_cnt_q);
                  end
`ifdef PRBS_RESYNC_EN
                  if (mismatch_w) begin
                     if (miss_run_q == 5'(RESYNC_MISSES - 1)) begin
                        miss_run_q <= '0;
                        sync_cnt_q <= '0;
                        state_q    <= SYNC;
                     end else begin
                        miss_run_q <= miss_run_q + 5'd1;
                     end
                  end else begin
                     miss_run_q <= '0;
                  end
`endif
               end
            end
            REPORT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.error_bits_out = err_out_q;
   assign bus.total_bits_out = tot_out_q;
   assign bus.send_data      = send_q;
   assign bus.wordtest       = wordtest_q;
   assign bus.countertest    = countertest_q;
   assign bus.bitin          = bitin_q;
   assign bus.bitout         = bitout_w;

endmodule

// File: tb/tb_prbs_receiver.sv
// tb_prbs_receiver: scoreboard bench for prbs_receiver. A reference PRBS7
// model drives the short-window instance; the error-injecting generator
// drives a full-length-window instance.
module tb_prbs_receiver;
   import prbs_pkg::*;

   localparam logic [15:0] W  = 16'd1000;
   localparam logic [15:0] WL = 16'd65535;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] err_rate;
   logic        gen_bit;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prbs_receiver_if bus ();
   prbs_receiver_if bus_l ();

   prbs_receiver #(.WINDOW_LEN(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   prbs_receiver #(.WINDOW_LEN(WL)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bus_l.slave)
   );

   prbs_gen gen (
      .clk          (clk),
      .rst          (rst),
      .error_rate_i (err_rate),
      .bit_o        (gen_bit)
   );

   assign bus_l.bit_in = gen_bit;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference stream: x^7+x^6+1, optional single inversion or stuck-at-0
   logic [6:0] m_s = 7'h55;
   logic       stuck = 1'b0;
   int         inj_cyc = -1;

   always @(negedge clk) begin
      logic b;
      b = m_s[6] ^ m_s[5];
      m_s = {m_s[5:0], b};
      bus.bit_in = stuck ? 1'b0 : (b ^ (cyc == inj_cyc));
   end

   typedef struct {
      logic [31:0] err;
      logic [31:0] tot;
      int          at;
   } exp_t;

   exp_t sbq[$];

   always @(negedge clk) begin
      exp_t e;
      if (bus.send_data === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_send", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("err_bits", bus.error_bits_out, e.err);
            chk("total_bits", bus.total_bits_out, e.tot);
            chk("send_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic launch(input bit expect_it, input logic [31:0] exp_err, output int n);
      @(negedge clk);
      bus.get_word = 1'b1;
      n = cyc;
      if (expect_it) sbq.push_back('{err: exp_err, tot: 32'(W), at: n + int'(W) + 9});
      @(negedge clk);
      bus.get_word = 1'b0;
   endtask

   task automatic wait_sb();
      for (int i = 0; i < 3000 && sbq.size() != 0; i++) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int  n;
      bit  got;
      rst            = 1'b1;
      err_rate       = 16'd0;
      bus.get_word   = 1'b0;
      bus_l.get_word = 1'b0;

      // reset state
      repeat (5) @(negedge clk);
      chk("rst_err", bus.error_bits_out, 32'd0);
      chk("rst_tot", bus.total_bits_out, 32'd0);
      chk("rst_send", 32'(bus.send_data), 32'd0);
      chk("rst_wordtest", 32'(bus.wordtest), 32'd0);
      chk("rst_counter", 32'(bus.countertest), 32'd0);
      chk("rst_bitin", 32'(bus.bitin), 32'd0);
      chk("rst_bitout", 32'(bus.bitout), 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // clean window
      launch(1'b1, 32'd0, n);
      wait_sb();

      // single inverted bit inside the window
      launch(1'b1, 32'd1, n);
      inj_cyc = n + 506;
      wait_sb();
      repeat (20) @(negedge clk);
      chk("hold_err", bus.error_bits_out, 32'd1);
      chk("hold_tot", bus.total_bits_out, 32'(W));
      chk("hold_send", 32'(bus.send_data), 32'd0);

      // get_word held high: restart only from IDLE after REPORT
      @(negedge clk);
      bus.get_word = 1'b1;
      n = cyc;
      sbq.push_back('{err: 32'd0, tot: 32'(W), at: n + int'(W) + 9});
      sbq.push_back('{err: 32'd0, tot: 32'(W), at: n + 2 * int'(W) + 19});
      wait_cyc(n + int'(W) + 11);
      bus.get_word = 1'b0;
      wait_sb();

      // dead link: stuck at zero keeps the FSM in SYNC
      stuck = 1'b1;
      repeat (3) @(negedge clk);
      launch(1'b0, 32'd0, n);
      repeat (200) @(negedge clk);
      chk("stuck_state", 32'(dut.state_q), 32'(SYNC));
      chk("stuck_counter", 32'(bus.countertest), 32'd0);
      chk("stuck_wordtest", 32'(bus.wordtest), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      stuck = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // mid-window get_word ignored, then reset discards the window
      launch(1'b0, 32'd0, n);
      wait_cyc(n + 100);
      bus.get_word = 1'b1;
      @(negedge clk);
      bus.get_word = 1'b0;
      wait_cyc(n + 201);
      chk("no_restart_counter", 32'(bus.countertest), 32'd193);
      wait_cyc(n + 307);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
      chk("midrst_counter", 32'(bus.countertest), 32'd0);
      chk("midrst_wordtest", 32'(bus.wordtest), 32'd0);
      chk("midrst_err", bus.error_bits_out, 32'd0);
      chk("midrst_tot", bus.total_bits_out, 32'd0);
      chk("midrst_send", 32'(bus.send_data), 32'd0);

      // full-length window from the generator at error_rate 100
      @(negedge clk);
      bus_l.get_word = 1'b1;
      n = cyc;
      @(negedge clk);
      bus_l.get_word = 1'b0;
      wait_cyc(n + 12);
      err_rate = 16'd100;
      got = 1'b0;
      for (int i = 0; i < 66000 && !got; i++) begin
         @(negedge clk);
         if (bus_l.send_data === 1'b1) got = 1'b1;
      end
      chk("long_send_seen", 32'(got), 32'd1);
      chk("long_send_cycle", 32'(cyc), 32'(n + int'(WL) + 9));
      chk("long_tot", bus_l.total_bits_out, 32'(WL));
      chk("long_err_ge_60", 32'(bus_l.error_bits_out >= 32'd60), 32'd1);
      chk("long_err_le_140", 32'(bus_l.error_bits_out <= 32'd140), 32'd1);
      err_rate = 16'd0;

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
